// File: rtl/fb_pkg.sv
// Shared framebuffer address map for the Mandelbrot display path.
// Both the write side (fb_writer) and the VGA scan-out side import this
// package, so the two ends always agree on banking and address layout.
package fb_pkg;

    // Logical framebuffer geometry (half the VGA resolution in each axis).
    localparam int FB_WIDTH      = 320;
    localparam int FB_HEIGHT     = 240;
    localparam int ROWS_PER_BANK = 16;
    localparam int BANK_DEPTH    = FB_WIDTH * ROWS_PER_BANK;

    // RAM-facing widths.
    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 12;
    localparam int BANK_WIDTH = 4;

    // Counter widths derived from the geometry.
    localparam int COL_WIDTH = $clog2(FB_WIDTH);
    localparam int ROW_WIDTH = $clog2(FB_HEIGHT + 1);
    localparam int ROW_SHIFT = $clog2(ROWS_PER_BANK);

    // Colour field slices within a pixel word {R, G, B}.
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } wr_state_t;

endpackage

// File: rtl/fb_writer_if.sv
// Pixel stream handshake plus framebuffer RAM write bus.
// The slave modport is the writer's view; the master modport is the view of
// whatever sits around it (pixel producer on one side, RAM on the other).
interface fb_writer_if
    import fb_pkg::*;
    ();

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_last;
    logic                  o_ready;
    logic                  o_we;
    logic [ADDR_WIDTH-1:0] o_addr_wr;
    logic [DATA_WIDTH-1:0] o_data_wr;
    logic [BANK_WIDTH-1:0] o_bank;

    modport master (
        output i_valid, i_data, i_last,
        input  o_ready, o_we, o_addr_wr, o_data_wr, o_bank
    );

    modport slave (
        input  i_valid, i_data, i_last,
        output o_ready, o_we, o_addr_wr, o_data_wr, o_bank
    );

endinterface

// File: rtl/raster_counter.sv
// Raster position counters for the framebuffer writer.
// Tracks col/row in raster order and a running in-bank address that wraps at
// each bank boundary, so no multiplier is needed to form row*FB_WIDTH+col.
module raster_counter
    import fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  advance_i,
    output logic [COL_WIDTH-1:0]  col_o,
    output logic [ROW_WIDTH-1:0]  row_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [BANK_WIDTH-1:0] bank_o,
    output logic                  last_pixel_o
);

    logic [COL_WIDTH-1:0]  col_q,  col_d;
    logic [ROW_WIDTH-1:0]  row_q,  row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  col_end;
    logic                  bank_row_end;

    assign col_end      = (col_q == COL_WIDTH'(FB_WIDTH - 1));
    assign bank_row_end = (row_q[ROW_SHIFT-1:0] == ROW_SHIFT'(ROWS_PER_BANK - 1));

    // Next position: clear wins, otherwise step one pixel in raster order.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (advance_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (col_end && bank_row_end) begin
                addr_d = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign addr_o       = addr_q;
    assign bank_o       = row_q[ROW_SHIFT +: BANK_WIDTH];
    assign last_pixel_o = col_end && (row_q == ROW_WIDTH'(FB_HEIGHT - 1));

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write-side controller.
// Accepts raster-order pixels over valid/ready and issues one registered RAM
// write per accepted pixel, one cycle later, with bank/address taken from the
// pixel's own raster position. Frames end on pixel count, never on i_last;
// a misplaced i_last only raises the sticky error flag.
module fb_writer
    import fb_pkg::*;
(
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    fb_writer_if.slave   fb,
    output logic         o_busy,
    output logic         o_frame_done,
    output logic         o_err
);

    wr_state_t             state_q;
    logic                  ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  accept;
    logic                  cnt_clear;
    logic [COL_WIDTH-1:0]  cnt_col;
    logic [ROW_WIDTH-1:0]  cnt_row;
    logic [ADDR_WIDTH-1:0] cnt_addr;
    logic [BANK_WIDTH-1:0] cnt_bank;
    logic                  cnt_last;

    // Abort suppresses the pixel offered in the same cycle.
    assign accept    = ready_q && fb.i_valid && !i_abort;
    assign cnt_clear = ((state_q == ST_IDLE) && i_start && !i_abort) ||
                       ((state_q == ST_RUN)  && i_abort);

    raster_counter u_raster (
        .clk          (clk),
        .rst_n        (i_rst_n),
        .clear_i      (cnt_clear),
        .advance_i    (accept),
        .col_o        (cnt_col),
        .row_o        (cnt_row),
        .addr_o       (cnt_addr),
        .bank_o       (cnt_bank),
        .last_pixel_o (cnt_last)
    );

    // Frame FSM with registered handshake, write port and status outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            bank_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= accept;
            done_q <= 1'b0;
            if (accept) begin
                addr_q <= cnt_addr;
                data_q <= fb.i_data;
                bank_q <= cnt_bank;
                if (fb.i_last != cnt_last) begin
                    err_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (accept && cnt_last) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Column and row are carried for scan-out alignment debug only.
    logic unused_pos;
    assign unused_pos = ^{cnt_col, cnt_row};

    assign fb.o_ready    = ready_q;
    assign fb.o_we       = we_q;
    assign fb.o_addr_wr  = addr_q;
    assign fb.o_data_wr  = data_q;
    assign fb.o_bank     = bank_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed testbench for fb_writer.
// A cycle-level reference model of the writer tracks expected handshake,
// write-port and status values; hand-computed constants pin down the
// bank/address boundaries of the raster map.
module tb_fb_writer;
    import fb_pkg::*;

    localparam int TOTAL     = FB_WIDTH * FB_HEIGHT;
    localparam int ABORT_IDX = 37 * FB_WIDTH + 100;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic err;

    fb_writer_if fbBus ();

    fb_writer dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .fb           (fbBus),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_err        (err)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int seqErrors   = 0;
    int dutWrites   = 0;
    int pixIdx      = 0;
    int expIdx      = 0;
    int cycleNo     = 0;

    bit                    modelRun = 1'b0;
    bit                    expWe    = 1'b0;
    bit                    expDone  = 1'b0;
    bit                    expErr   = 1'b0;
    logic [ADDR_WIDTH-1:0] expAddr  = '0;
    logic [BANK_WIDTH-1:0] expBank  = '0;
    logic [DATA_WIDTH-1:0] expData  = '0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic compareCycle();
        bit bad;
        bad = 1'b0;
        if (fbBus.o_we) dutWrites++;
        if (fbBus.o_we !== expWe) bad = 1'b1;
        if (expWe && ((fbBus.o_addr_wr !== expAddr) || (fbBus.o_bank !== expBank) ||
                      (fbBus.o_data_wr !== expData))) bad = 1'b1;
        if (fbBus.o_ready !== modelRun) bad = 1'b1;
        if (busy !== modelRun) bad = 1'b1;
        if (done !== expDone) bad = 1'b1;
        if (err !== expErr) bad = 1'b1;
        if (bad) begin
            seqErrors++;
            if (seqErrors <= 5)
                $display("[TB] divergence at cycle %0d: we=%b addr=%0d bank=%0d rdy=%b done=%b err=%b",
                         cycleNo, fbBus.o_we, fbBus.o_addr_wr, fbBus.o_bank,
                         fbBus.o_ready, done, err);
        end
        if (expWe) begin
            if (expIdx == 0) begin
                checkOutput("w0_addr", 32'(fbBus.o_addr_wr), 32'd0);
                checkOutput("w0_bank", 32'(fbBus.o_bank), 32'd0);
            end
            if (expIdx == 319) begin
                checkOutput("w319_addr", 32'(fbBus.o_addr_wr), 32'd319);
                checkOutput("w319_bank", 32'(fbBus.o_bank), 32'd0);
            end
            if (expIdx == 5119) begin
                checkOutput("w5119_addr", 32'(fbBus.o_addr_wr), 32'd5119);
                checkOutput("w5119_bank", 32'(fbBus.o_bank), 32'd0);
            end
            if (expIdx == 5120) begin
                checkOutput("w5120_addr", 32'(fbBus.o_addr_wr), 32'd0);
                checkOutput("w5120_bank", 32'(fbBus.o_bank), 32'd1);
            end
            if (expIdx == TOTAL - 1) begin
                checkOutput("wlast_addr", 32'(fbBus.o_addr_wr), 32'd5119);
                checkOutput("wlast_bank", 32'(fbBus.o_bank), 32'd14);
                checkOutput("wlast_done", 32'(done), 32'd1);
            end
        end
    endtask

    // Drive one cycle of inputs, step the reference model at the edge,
    // then compare outputs on the falling edge.
    task automatic applyStimulus(input logic valid, input logic st, input logic ab,
                                 input logic last, input logic [DATA_WIDTH-1:0] data);
        int row;
        int col;
        fbBus.i_valid = valid;
        fbBus.i_data  = data;
        fbBus.i_last  = last;
        start         = st;
        abort         = ab;
        @(posedge clk);
        expWe   = 1'b0;
        expDone = 1'b0;
        if (rst_n) begin
            if (modelRun) begin
                if (ab) begin
                    modelRun = 1'b0;
                    pixIdx   = 0;
                end else if (valid) begin
                    row     = pixIdx / FB_WIDTH;
                    col     = pixIdx % FB_WIDTH;
                    expWe   = 1'b1;
                    expIdx  = pixIdx;
                    expAddr = ADDR_WIDTH'((row % ROWS_PER_BANK) * FB_WIDTH + col);
                    expBank = BANK_WIDTH'(row / ROWS_PER_BANK);
                    expData = data;
                    if (last != (pixIdx == TOTAL - 1)) expErr = 1'b1;
                    if (pixIdx == TOTAL - 1) begin
                        expDone  = 1'b1;
                        modelRun = 1'b0;
                    end
                    pixIdx++;
                end
            end else if (st && !ab) begin
                modelRun = 1'b1;
                pixIdx   = 0;
                expErr   = 1'b0;
            end
        end
        @(negedge clk);
        cycleNo++;
        compareCycle();
    endtask

    initial begin
        int base;
        int cyc;
        logic v;

        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        fbBus.i_valid = 1'b0;
        fbBus.i_data  = '0;
        fbBus.i_last  = 1'b0;

        // Reset values.
        #12;
        checkOutput("rst_ready", 32'(fbBus.o_ready), 32'd0);
        checkOutput("rst_we", 32'(fbBus.o_we), 32'd0);
        checkOutput("rst_addr", 32'(fbBus.o_addr_wr), 32'd0);
        checkOutput("rst_data", 32'(fbBus.o_data_wr), 32'd0);
        checkOutput("rst_bank", 32'(fbBus.o_bank), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Valid in IDLE is not consumed.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'hABC);
        checkOutput("idle_ready", 32'(fbBus.o_ready), 32'd0);
        checkOutput("idle_writes", 32'(dutWrites), 32'd0);

        // Start together with abort in IDLE stays IDLE.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("startabort_ready", 32'(fbBus.o_ready), 32'd0);
        checkOutput("startabort_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("startabort_ready2", 32'(fbBus.o_ready), 32'd0);

        // Full gapless frame, with a stray start mid-frame.
        $display("[TB] full frame");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'(($urandom)));
        checkOutput("start_ready", 32'(fbBus.o_ready), 32'd1);
        base = dutWrites;
        for (int i = 0; i < TOTAL; i++)
            applyStimulus(1'b1, (i == 1000), 1'b0, (i == TOTAL - 1), 12'($urandom));
        checkOutput("full_writes", 32'(dutWrites - base), 32'(TOTAL));
        checkOutput("full_err", 32'(err), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'($urandom));
        checkOutput("full_ready_after", 32'(fbBus.o_ready), 32'd0);
        checkOutput("full_busy_after", 32'(busy), 32'd0);
        checkOutput("full_done_after", 32'(done), 32'd0);

        // Gapped stream then abort on pixel (100, 37).
        $display("[TB] gapped frame with abort");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        base = dutWrites;
        cyc  = 0;
        while (pixIdx < ABORT_IDX) begin
            v = (cyc < 1200) ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(v, 1'b0, 1'b0, 1'b0, 12'($urandom));
            cyc++;
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'($urandom));
        checkOutput("abort_we", 32'(fbBus.o_we), 32'd0);
        checkOutput("abort_ready", 32'(fbBus.o_ready), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_writes", 32'(dutWrites - base), 32'(ABORT_IDX));

        // Restart from origin, misplaced i_last on pixel (5, 0).
        $display("[TB] restart with misplaced last");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, (i == 5), 12'($urandom));
            if (i == 0) begin
                checkOutput("restart_addr", 32'(fbBus.o_addr_wr), 32'd0);
                checkOutput("restart_bank", 32'(fbBus.o_bank), 32'd0);
            end
            if (i == 4) checkOutput("err_before", 32'(err), 32'd0);
            if (i == 5) checkOutput("err_set", 32'(err), 32'd1);
        end
        checkOutput("err_held", 32'(err), 32'd1);
        checkOutput("last_no_stop", 32'(fbBus.o_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        checkOutput("err_sticky_idle", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        checkOutput("err_cleared", 32'(err), 32'd0);

        // Asynchronous reset mid-frame, between clock edges.
        $display("[TB] async reset mid-frame");
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, (i == 0), 12'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        modelRun = 1'b0;
        expWe    = 1'b0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        pixIdx   = 0;
        checkOutput("arst_ready", 32'(fbBus.o_ready), 32'd0);
        checkOutput("arst_we", 32'(fbBus.o_we), 32'd0);
        checkOutput("arst_addr", 32'(fbBus.o_addr_wr), 32'd0);
        checkOutput("arst_data", 32'(fbBus.o_data_wr), 32'd0);
        checkOutput("arst_bank", 32'(fbBus.o_bank), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        base = dutWrites;
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'($urandom));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'($urandom));
        checkOutput("post_reset_writes", 32'(dutWrites - base), 32'd0);
        checkOutput("post_reset_ready", 32'(fbBus.o_ready), 32'd0);

        checkOutput("seq_errors", 32'(seqErrors), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
